// File: rtl/lsu_axil.sv
// lsu_axil: core-side load/store unit bridging single scalar requests to an
// AXI-Lite master port. One transaction outstanding at a time. Stores carry a
// lane-0-justified strobe/data built from the access size. Loads sign- or
// zero-extend the lane-0-justified read data.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_*               core request (valid/ready, we, addr, size, unsigned, wdata)
//   resp_*              core response (valid/ready, rdata, err)
//   m_aw*/m_w*/m_b*     AXI-Lite write channels
//   m_ar*/m_r*          AXI-Lite read channels
module lsu_axil #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,

  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  aw_done, w_done;

  logic                  aw_hs, w_hs;
  logic [STRB_WIDTH-1:0] strb_enc;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] rext;

  // All outputs decode registered state or drive registered payload.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign m_awaddr   = addr_q;
  assign m_araddr   = addr_q;
  assign m_awprot   = '0;
  assign m_arprot   = '0;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = strb_q;
  // AW and W drop independently once their own handshake has completed.
  assign m_awvalid  = (state == WR) && !aw_done;
  assign m_wvalid   = (state == WR) && !w_done;
  assign m_bready   = (state == WB);
  assign m_arvalid  = (state == RA);
  assign m_rready   = (state == RD);

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;

  always_comb begin
    strb_enc = '0;
    case (req_size)
      2'd0:    strb_enc = STRB_WIDTH'(4'b0001);
      2'd1:    strb_enc = STRB_WIDTH'(4'b0011);
      2'd2:    strb_enc = '1;
      default: strb_enc = '0;
    endcase
  end

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      wmask[i*8 +: 8] = {8{strb_enc[i]}};
    end
  end

  always_comb begin
    rext = m_rdata;
    case (size_q)
      2'd0:    rext = {{(DATA_WIDTH-8){~uns_q & m_rdata[7]}}, m_rdata[7:0]};
      2'd1:    rext = {{(DATA_WIDTH-16){~uns_q & m_rdata[15]}}, m_rdata[15:0]};
      default: rext = m_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_size == 2'd3) state_nxt = RESP;
          else if (req_we)      state_nxt = WR;
          else                  state_nxt = RA;
        end
      end
      WR: begin
        // A channel counts as done if it finished earlier or handshakes now.
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WB;
      end
      WB:      if (m_bvalid)   state_nxt = RESP;
      RA:      if (m_arready)  state_nxt = RD;
      RD:      if (m_rvalid)   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata & wmask;
            strb_q  <= strb_enc;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            err_q   <= (req_size == 2'd3);
          end
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WB: begin
          if (m_bvalid) begin
            err_q   <= (m_bresp != 2'b00);
            rdata_q <= '0;
          end
        end
        RD: begin
          if (m_rvalid) begin
            rdata_q <= rext;
            err_q   <= (m_rresp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil.sv
module tb_lsu_axil;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    m_bresp, m_rresp;

  lsu_axil #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Reference model: what a transaction must look like, from the access rules.
  function automatic logic [31:0] byte_mask(input logic [1:0] sz);
    int nbits;
    nbits = 8 * (1 << sz);
    return (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
  endfunction

  function automatic logic [3:0] strb_of(input logic [1:0] sz);
    return 4'((32'd1 << (32'd1 << sz)) - 32'd1);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] m, top, v;
    m   = byte_mask(sz);
    top = m ^ (m >> 1);
    v   = d & m;
    if (!uns && ((v & top) != 0)) v = v | ~m;
    return v;
  endfunction

  logic        exp_active = 1'b0, exp_bus = 1'b0, exp_we = 1'b0, exp_err = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [3:0]  exp_strb = '0;
  logic [31:0] exp_wdata = '0, exp_rdata = '0;
  logic        abort = 1'b0;

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, resp_cnt = 0;
  logic [15:0] last_awaddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
  logic [15:0] p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0, p_rdata = '0;
  logic [3:0]  p_wstrb = '0;
  logic        p_err = 0;

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      if (m_awvalid && m_awready) begin aw_cnt++; last_awaddr = m_awaddr; end
      if (m_wvalid && m_wready) begin w_cnt++; last_wdata = m_wdata; last_wstrb = m_wstrb; end
      if (m_bvalid && m_bready) b_cnt++;
      if (m_arvalid && m_arready) ar_cnt++;
      if (m_rvalid && m_rready) r_cnt++;
      if (resp_valid && resp_ready) resp_cnt++;

      if (!exp_active) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_no_outputs",
            32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, resp_valid}), 32'd0);
      end
      if (m_awvalid) begin
        chk("aw_allowed", 32'(exp_bus && exp_we), 32'd1);
        chk("awaddr", 32'(m_awaddr), 32'(exp_addr));
        chk("awprot", 32'(m_awprot), 32'd0);
      end
      if (m_wvalid) begin
        chk("w_allowed", 32'(exp_bus && exp_we), 32'd1);
        chk("wdata", m_wdata, exp_wdata);
        chk("wstrb", 32'(m_wstrb), 32'(exp_strb));
      end
      if (m_arvalid) begin
        chk("ar_allowed", 32'(exp_bus && !exp_we), 32'd1);
        chk("araddr", 32'(m_araddr), 32'(exp_addr));
        chk("arprot", 32'(m_arprot), 32'd0);
      end
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        chk("resp_no_bus", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
      end
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", 32'(m_awvalid), 32'd1);
        chk("awaddr_hold", 32'(m_awaddr), 32'(p_awaddr));
      end
      if (p_wv && !p_wr) begin
        chk("wvalid_hold", 32'(m_wvalid), 32'd1);
        chk("wdata_hold", m_wdata, p_wdata);
        chk("wstrb_hold", 32'(m_wstrb), 32'(p_wstrb));
      end
      if (p_arv && !p_arr) begin
        chk("arvalid_hold", 32'(m_arvalid), 32'd1);
        chk("araddr_hold", 32'(m_araddr), 32'(p_araddr));
      end
      if (p_rv && !p_rr) begin
        chk("resp_valid_hold", 32'(resp_valid), 32'd1);
        chk("resp_rdata_hold", resp_rdata, p_rdata);
        chk("resp_err_hold", 32'(resp_err), 32'(p_err));
      end
      p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
      p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
      p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
      p_rv = resp_valid; p_rr = resp_ready; p_rdata = resp_rdata; p_err = resp_err;
    end else begin
      p_awv = 0; p_wv = 0; p_arv = 0; p_rv = 0;
    end
  end

  // Channel drivers; all act at posedge+1 so the compare process sees settled inputs.
  function automatic logic valid_of(input int ch);
    case (ch)
      0:       return m_awvalid;
      1:       return m_wvalid;
      default: return m_arvalid;
    endcase
  endfunction

  task automatic set_ready(input int ch, input logic v);
    case (ch)
      0:       m_awready = v;
      1:       m_wready = v;
      default: m_arready = v;
    endcase
  endtask

  task automatic ready_drv(input int ch, input int dly);
    int n = 0;
    for (int g = 0; g < 200; g++) begin
      if (abort) return;
      if (valid_of(ch)) begin
        if (n >= dly) begin
          set_ready(ch, 1'b1);
          @(posedge clk); #1;
          set_ready(ch, 1'b0);
          return;
        end
        n++;
      end
      @(posedge clk); #1;
    end
    timeout("ready_drv");
  endtask

  task automatic b_drv(input int dly, input logic [1:0] resp, input int baw, input int bw,
                       input int bb);
    int g = 0;
    while (!(aw_cnt > baw && w_cnt > bw) && !abort && g < 200) begin @(posedge clk); #1; g++; end
    for (int i = 0; i < dly && !abort; i++) begin @(posedge clk); #1; end
    if (abort) return;
    if (g >= 200) begin timeout("b_wait_aw_w"); return; end
    m_bvalid = 1'b1; m_bresp = resp;
    g = 0;
    while (b_cnt == bb && !abort && g < 200) begin @(posedge clk); #1; g++; end
    m_bvalid = 1'b0; m_bresp = 2'b00;
    if (g >= 200) timeout("b_handshake");
  endtask

  task automatic r_drv(input int dly, input logic [31:0] d, input logic [1:0] resp,
                       input int bar, input int br);
    int g = 0;
    while (ar_cnt == bar && !abort && g < 200) begin @(posedge clk); #1; g++; end
    for (int i = 0; i < dly && !abort; i++) begin @(posedge clk); #1; end
    if (abort) return;
    if (g >= 200) begin timeout("r_wait_ar"); return; end
    m_rvalid = 1'b1; m_rdata = d; m_rresp = resp;
    g = 0;
    while (r_cnt == br && !abort && g < 200) begin @(posedge clk); #1; g++; end
    m_rvalid = 1'b0; m_rdata = 32'hA5A5_A5A5; m_rresp = 2'b00;
    if (g >= 200) timeout("r_handshake");
  endtask

  task automatic resp_drv(input int rr_d, input int t0, output int lat,
                          output logic [31:0] d, output logic e);
    int g = 0;
    lat = -1; d = '0; e = 1'b0;
    while (!resp_valid && !abort && g < 200) begin @(posedge clk); #1; g++; end
    if (abort) return;
    if (!resp_valid) begin timeout("resp_valid"); return; end
    lat = cyc - t0; d = resp_rdata; e = resp_err;
    for (int i = 0; i < rr_d && !abort; i++) begin @(posedge clk); #1; end
    if (abort) return;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [1:0] resp, input int aw_d, input int w_d, input int b_d,
                        input int ar_d, input int r_d, input int rr_d, input int exp_lat,
                        output logic [31:0] got_d, output logic got_e);
    int   baw, bw, bb, bar, br, bresp_c, t0, lat;
    logic bus;
    @(posedge clk); #1;
    bus       = (sz != 2'd3);
    exp_we    = we;
    exp_addr  = addr;
    exp_bus   = bus;
    exp_strb  = bus ? strb_of(sz) : 4'd0;
    exp_wdata = bus ? (wdata & byte_mask(sz)) : 32'd0;
    exp_err   = !bus || (resp != 2'b00);
    exp_rdata = (!bus || we) ? 32'd0 : load_ext(rdata, sz, uns);
    exp_active = 1'b1;
    baw = aw_cnt; bw = w_cnt; bb = b_cnt; bar = ar_cnt; br = r_cnt; bresp_c = resp_cnt;
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
    req_unsigned = uns; req_wdata = wdata;
    t0 = cyc;
    fork
      begin
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_size = ~sz;
        req_unsigned = ~uns; req_wdata = ~wdata;
      end
      begin if (bus && we) ready_drv(0, aw_d); end
      begin if (bus && we) ready_drv(1, w_d); end
      begin if (bus && we) b_drv(b_d, resp, baw, bw, bb); end
      begin if (bus && !we) ready_drv(2, ar_d); end
      begin if (bus && !we) r_drv(r_d, rdata, resp, bar, br); end
      resp_drv(rr_d, t0, lat, got_d, got_e);
    join
    if (!abort) begin
      chk("aw_count", 32'(aw_cnt - baw), 32'(bus && we));
      chk("w_count", 32'(w_cnt - bw), 32'(bus && we));
      chk("b_count", 32'(b_cnt - bb), 32'(bus && we));
      chk("ar_count", 32'(ar_cnt - bar), 32'(bus && !we));
      chk("r_count", 32'(r_cnt - br), 32'(bus && !we));
      chk("resp_count", 32'(resp_cnt - bresp_c), 32'd1);
      if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    end
    exp_active = 1'b0;
  endtask

  logic [31:0] gd;
  logic        ge;

  initial begin
    req_valid = 0; req_we = 0; req_addr = '0; req_size = '0; req_unsigned = 0; req_wdata = '0;
    resp_ready = 0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 2'b00; m_rvalid = 0; m_rresp = 2'b00; m_rdata = 32'hA5A5_A5A5;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_valids", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, resp_valid}), 32'd0);
    chk("rst_awaddr", 32'(m_awaddr), 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    #20 rst = 1'b1;

    // Byte store: lane-0 data masked to one byte, full unaligned address.
    do_txn(1, 16'h0005, 2'd0, 0, 32'hDEAD_BEEF, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, 3, gd, ge);
    chk("t1_awaddr", 32'(last_awaddr), 32'h0000_0005);
    chk("t1_wstrb", 32'(last_wstrb), 32'h1);
    chk("t1_wdata", last_wdata, 32'h0000_00EF);
    chk("t1_err", 32'(ge), 32'd0);
    chk("t1_rdata", gd, 32'd0);

    // Half loads, signed then unsigned.
    do_txn(0, 16'h0002, 2'd1, 0, 32'h0, 32'h1234_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 3, gd, ge);
    chk("t2_signed_half", gd, 32'hFFFF_F00D);
    do_txn(0, 16'h0002, 2'd1, 1, 32'h0, 32'h1234_F00D, 2'b00, 0, 0, 0, 0, 0, 0, 3, gd, ge);
    chk("t2_unsigned_half", gd, 32'h0000_F00D);

    // Word store: W accepted 3 cycles before AW.
    do_txn(1, 16'h0100, 2'd2, 0, 32'hCAFE_F00D, 32'h0, 2'b00, 3, 0, 0, 0, 0, 0, -1, gd, ge);
    chk("t3_wstrb", 32'(last_wstrb), 32'hF);
    chk("t3_wdata", last_wdata, 32'hCAFE_F00D);

    // Signed byte load with SLVERR.
    do_txn(0, 16'h0013, 2'd0, 0, 32'h0, 32'h0000_0080, 2'b10, 0, 0, 0, 2, 1, 0, -1, gd, ge);
    chk("t4_err", 32'(ge), 32'd1);
    chk("t4_rdata", gd, 32'hFFFF_FF80);

    // Reserved size, load and store: error, no bus activity.
    do_txn(0, 16'h0040, 2'd3, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, -1, gd, ge);
    chk("t5_err_ld", 32'(ge), 32'd1);
    chk("t5_rdata_ld", gd, 32'd0);
    do_txn(1, 16'h0044, 2'd3, 0, 32'h1111_2222, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, -1, gd, ge);
    chk("t5_err_st", 32'(ge), 32'd1);

    // Word load with the core stalling the response for 5 cycles.
    do_txn(0, 16'h0204, 2'd2, 0, 32'h0, 32'h89AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 5, 3, gd, ge);
    chk("t6_rdata", gd, 32'h89AB_CDEF);

    // Unaligned half store with delayed handshakes and SLVERR on B.
    do_txn(1, 16'h0003, 2'd1, 0, 32'h1234_5678, 32'h0, 2'b10, 1, 2, 2, 0, 0, 0, -1, gd, ge);
    chk("t7_wstrb", 32'(last_wstrb), 32'h3);
    chk("t7_wdata", last_wdata, 32'h0000_5678);
    chk("t7_err", 32'(ge), 32'd1);

    // Reset asserted while waiting in WB.
    fork
      do_txn(1, 16'h0300, 2'd2, 0, 32'h0BAD_0BAD, 32'h0, 2'b00, 0, 0, 30, 0, 0, 0, -1, gd, ge);
      begin
        int g = 0;
        @(posedge clk); #1;
        while (!m_bready && g < 50) begin @(posedge clk); #1; g++; end
        if (!m_bready) timeout("reach_wb");
        abort = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("wb_rst_req_ready", 32'(req_ready), 32'd1);
        chk("wb_rst_valids",
            32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, resp_valid}), 32'd0);
      end
    join
    @(posedge clk); #1;
    m_bvalid = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_arready = 0; resp_ready = 0;
    abort = 1'b0;
    #2 rst = 1'b1;
    do_txn(1, 16'h0301, 2'd0, 0, 32'h0000_00A5, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, 3, gd, ge);
    chk("t8_wdata", last_wdata, 32'h0000_00A5);
    chk("t8_err", 32'(ge), 32'd0);
    do_txn(0, 16'h0301, 2'd0, 1, 32'h0, 32'h7777_77C3, 2'b00, 0, 0, 0, 0, 0, 0, 3, gd, ge);
    chk("t8_unsigned_byte", gd, 32'h0000_00C3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule
